instr_loader: RTL and testbench

INSTR_LOADER -- requirements
Module: instr_loader

---
 rtl/instr_loader_pkg.sv | 21 ++
 rtl/instr_loader_if.sv | 21 ++
 rtl/instr_loader_byte_assembler.sv | 49 ++++
 rtl/instr_loader.sv | 131 +++++++++++++
 tb/tb_instr_loader.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/instr_loader_pkg.sv
// Shared types and constants for the instruction loader and its byte packer.
package loader_pkg;

    localparam int HDR_BYTES  = 4;
    localparam int WORD_BYTES = 4;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        DATA,
        WRITE,
        DONE,
        ERROR
    } loader_state_e;

    // Byte address of word 'idx' in instruction memory, wrapping at 2^32.
    function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [31:0] idx);
        return base + (idx << 2);
    endfunction

endpackage

// File: rtl/instr_loader_if.sv
// Byte-stream input and instruction-memory write bus of the loader.
interface instr_loader_if;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        w_en;
    logic [31:0] w_addr;
    logic [31:0] w_instr;

    // Host side: supplies program bytes, observes memory writes.
    modport master (
        output byte_valid, byte_data,
        input  byte_ready, w_en, w_addr, w_instr
    );

    // Loader side.
    modport slave (
        input  byte_valid, byte_data,
        output byte_ready, w_en, w_addr, w_instr
    );
endinterface

// File: rtl/instr_loader_byte_assembler.sv
// Packs little-endian bytes into 32-bit words. The full word and its
// word_valid pulse are presented in the same cycle the last byte is accepted,
// so the controller can leave a byte-accepting state without over-accepting.
module byte_assembler
    import loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        byte_en,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_valid
);

    // Header and data words share one counter, so both must be one word wide.
    localparam logic [1:0] LAST_BYTE = 2'(WORD_BYTES - 1);

    logic [31:0] shift_q, shift_d;
    logic [1:0]  cnt_q, cnt_d;

    // Shift new bytes in from the top so the first byte lands in bits 7:0.
    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        if (clear) begin
            shift_d = '0;
            cnt_d   = '0;
        end else if (byte_en) begin
            shift_d = {byte_in, shift_q[31:8]};
            cnt_d   = cnt_q + 2'd1;
        end
    end

    assign word       = {byte_in, shift_q[31:8]};
    assign word_valid = byte_en && !clear && (cnt_q == LAST_BYTE);

    // Packing state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/instr_loader.sv
// Boot-time instruction loader: reads a 4-byte word count followed by the
// program words from a byte stream, writes them to instruction memory and
// holds the CPU until the whole program is in place.
module instr_loader
    import loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MAX_WORDS = 1024
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    instr_loader_if.slave   bus,
    output logic            cpu_hold,
    output logic            done,
    output logic            err
);

    localparam logic [31:0] MAX_W = 32'(MAX_WORDS);

    loader_state_e state_q, state_d;
    logic [31:0]   n_q, n_d;
    logic [31:0]   idx_q, idx_d;
    logic          byte_ready_q, byte_ready_d;
    logic          w_en_q, w_en_d;
    logic [31:0]   w_addr_q, w_addr_d;
    logic [31:0]   w_instr_q, w_instr_d;
    logic          cpu_hold_q, cpu_hold_d;
    logic          done_q, done_d;
    logic          err_q, err_d;

    logic          clear;
    logic          byte_en;
    logic [31:0]   word;
    logic          word_valid;

    // byte_ready is registered from the state, so a transfer always matches the state.
    assign byte_en = bus.byte_valid && byte_ready_q;

    byte_assembler u_asm (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .byte_en    (byte_en),
        .byte_in    (bus.byte_data),
        .word       (word),
        .word_valid (word_valid)
    );

    // Next state and next (registered) outputs; outputs decode the next state.
    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        idx_d   = idx_q;
        clear   = 1'b0;
        case (state_q)
            IDLE, DONE, ERROR: begin
                if (start) begin
                    state_d = HDR;
                    clear   = 1'b1;
                end
            end
            HDR: begin
                if (word_valid) begin
                    n_d = word;
                    if (word == 32'd0) begin
                        state_d = DONE;
                    end else if (word > MAX_W) begin
                        state_d = ERROR;
                    end else begin
                        state_d = DATA;
                        idx_d   = 32'd0;
                    end
                end
            end
            DATA: begin
                if (word_valid) state_d = WRITE;
            end
            WRITE: begin
                idx_d   = idx_q + 32'd1;
                state_d = (idx_q + 32'd1 == n_q) ? DONE : DATA;
            end
            default: state_d = IDLE;
        endcase

        byte_ready_d = (state_d == HDR) || (state_d == DATA);
        // WRITE is only entered from DATA on word_valid, so word is the assembled instruction.
        w_en_d       = (state_d == WRITE);
        w_addr_d     = w_en_d ? word_addr(BASE_ADDR, idx_q) : w_addr_q;
        w_instr_d    = w_en_d ? word : w_instr_q;
        cpu_hold_d   = (state_d != DONE);
        done_d       = (state_d == DONE);
        err_d        = (state_d == ERROR);
    end

    // Controller state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            n_q          <= '0;
            idx_q        <= '0;
            byte_ready_q <= 1'b0;
            w_en_q       <= 1'b0;
            w_addr_q     <= BASE_ADDR;
            w_instr_q    <= '0;
            cpu_hold_q   <= 1'b1;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            n_q          <= n_d;
            idx_q        <= idx_d;
            byte_ready_q <= byte_ready_d;
            w_en_q       <= w_en_d;
            w_addr_q     <= w_addr_d;
            w_instr_q    <= w_instr_d;
            cpu_hold_q   <= cpu_hold_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign bus.byte_ready = byte_ready_q;
    assign bus.w_en       = w_en_q;
    assign bus.w_addr     = w_addr_q;
    assign bus.w_instr    = w_instr_q;
    assign cpu_hold       = cpu_hold_q;
    assign done           = done_q;
    assign err            = err_q;

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader: directed and random program loads
// compared against an expected write list built from the header and words.
module tb_instr_loader;

    localparam logic [31:0] BASE = 32'h0000_0000;
    localparam int          MAXW = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic start;
    logic cpu_hold, done, err;

    instr_loader_if bus ();

    instr_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .bus      (bus),
        .cpu_hold (cpu_hold),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] got_addr[$];
    logic [31:0] got_data[$];
    logic [31:0] wbuf[8];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Record every memory write; the loader must not accept bytes while writing.
    always @(negedge clk) begin
        if (rst_n && bus.w_en) begin
            got_addr.push_back(bus.w_addr);
            got_data.push_back(bus.w_instr);
            chk("ready_in_write", 32'(bus.byte_ready), 32'd0);
        end
    end

    task automatic check_reset_vals(input string tag);
        chk({tag, ".byte_ready"}, 32'(bus.byte_ready), 32'd0);
        chk({tag, ".w_en"},       32'(bus.w_en),       32'd0);
        chk({tag, ".w_addr"},     bus.w_addr,          BASE);
        chk({tag, ".w_instr"},    bus.w_instr,         32'd0);
        chk({tag, ".cpu_hold"},   32'(cpu_hold),       32'd1);
        chk({tag, ".done"},       32'(done),           32'd0);
        chk({tag, ".err"},        32'(err),            32'd0);
    endtask

    // Called at a falling edge; returns at the falling edge after the transfer.
    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        bus.byte_valid = 1'b1;
        bus.byte_data  = b;
        while (!bus.byte_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) chk("byte_timeout", 32'd1, 32'd0);
        else @(negedge clk);
        bus.byte_valid = 1'b0;
    endtask

    task automatic gap(input int mode);
        if (mode == 1) @(negedge clk);
        else if (mode == 2) repeat ($urandom_range(0, 3)) @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Load header n and, if legal, n words from wbuf; check the resulting writes.
    task automatic run_load(input string tag, input logic [31:0] n, input int gm, input int start_at);
        int   nsend;
        int   t;
        logic exp_err;
        got_addr.delete();
        got_data.delete();
        pulse_start();
        for (int i = 0; i < 4; i++) begin
            send_byte(n[8*i +: 8]);
            gap(gm);
        end
        exp_err = (n > 32'(MAXW));
        nsend   = (n == 32'd0 || exp_err) ? 0 : int'(n);
        for (int w = 0; w < nsend; w++) begin
            for (int b = 0; b < 4; b++) begin
                if (w * 4 + b == start_at) pulse_start();
                send_byte(wbuf[w][8*b +: 8]);
                gap(gm);
            end
        end
        t = 0;
        while (!(done || err) && t < 40) begin
            @(negedge clk);
            t++;
        end
        repeat (2) @(negedge clk);
        chk({tag, ".done"},       32'(done),           32'(!exp_err));
        chk({tag, ".err"},        32'(err),            32'(exp_err));
        chk({tag, ".cpu_hold"},   32'(cpu_hold),       32'(exp_err));
        chk({tag, ".byte_ready"}, 32'(bus.byte_ready), 32'd0);
        chk({tag, ".nwrites"},    32'(got_addr.size()), 32'(nsend));
        for (int i = 0; i < nsend && i < got_addr.size(); i++) begin
            chk({tag, ".addr"}, got_addr[i], BASE + 32'(4 * i));
            chk({tag, ".data"}, got_data[i], wbuf[i]);
        end
        if (nsend > 0) chk({tag, ".addr_hold"}, bus.w_addr, BASE + 32'(4 * (nsend - 1)));
    endtask

    initial begin
        rst_n          = 1'b0;
        start          = 1'b0;
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'h00;
        repeat (2) @(negedge clk);
        check_reset_vals("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Two-word program.
        wbuf[0] = 32'h0000_0013;
        wbuf[1] = 32'h0010_0093;
        run_load("two_words", 32'd2, 0, -1);

        // Empty program.
        run_load("empty", 32'd0, 0, -1);

        // Oversized header, then a normal load from ERROR.
        run_load("too_long", 32'd5, 0, -1);
        wbuf[0] = 32'hDEAD_BEEF;
        wbuf[1] = 32'h1234_5678;
        wbuf[2] = 32'hA5A5_0F0F;
        wbuf[3] = 32'h0000_0001;
        run_load("after_err", 32'd4, 0, -1);

        // Three words with a one-cycle gap after each byte.
        wbuf[0] = 32'h0040_0113;
        wbuf[1] = 32'h0020_8233;
        wbuf[2] = 32'hFFF0_0293;
        run_load("toggle", 32'd3, 1, -1);

        // start during DATA is ignored.
        run_load("start_in_data", 32'd3, 0, 6);

        // Reset after two of four data bytes.
        got_addr.delete();
        got_data.delete();
        pulse_start();
        for (int i = 0; i < 4; i++) send_byte((i == 0) ? 8'd2 : 8'd0);
        send_byte(8'h77);
        send_byte(8'h66);
        rst_n = 1'b0;
        #1;
        check_reset_vals("mid_reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_reset.nwrites", 32'(got_addr.size()), 32'd0);
        wbuf[0] = 32'h0BAD_F00D;
        wbuf[1] = 32'hC0FF_EE00;
        run_load("reload", 32'd2, 0, -1);

        // Random loads.
        for (int it = 0; it < 12; it++) begin
            logic [31:0] n;
            n = 32'($urandom_range(0, 6));
            for (int w = 0; w < 8; w++) wbuf[w] = $urandom;
            run_load("rand", n, $urandom_range(0, 2), -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
